// File: rtl/nibble_link_pkg.sv
// nibble_link_pkg: shared types and constants for the 4-bit serial shift link
package nibble_link_pkg;
   typedef enum logic {IDLE, SHIFT} state_t;
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;
   localparam int   WIDTH_DEF = 4;
endpackage

// File: rtl/nibble_serial_tx_if.sv
// nibble_serial_tx_if: valid/ready word handshake into the serial transmitter
interface nibble_serial_tx_if import nibble_link_pkg::*; #(parameter int WIDTH = WIDTH_DEF);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_dir;
   modport master (output in_valid, in_data, in_dir, input in_ready);
   modport slave  (input in_valid, in_data, in_dir, output in_ready);
endinterface

// File: rtl/bit_period_counter.sv
// bit_period_counter: counts 0..period per bit, period latched on load, tc marks the last cycle
module bit_period_counter import nibble_link_pkg::*; #(parameter int DIV_W = 8) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tc
);
   logic [DIV_W-1:0] cnt, period;
   assign tc = cnt == period;
   // restart and latch the period on load, wrap at terminal count while enabled
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt    <= '0;
         period <= '0;
      end else if (load) begin
         cnt    <= '0;
         period <= div;
      end else if (en)
         cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/nibble_serial_tx.sv
// nibble_serial_tx: buffered parallel-to-serial transmitter with programmable bit period
module nibble_serial_tx import nibble_link_pkg::*; #(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DIV_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   nibble_serial_tx_if.slave    bus,
   input  logic [DIV_W-1:0]     bit_div,
   output logic                 ser_out,
   output logic                 ser_en,
   output logic                 ser_dir,
   output logic                 busy,
   output logic                 done
);
   localparam int IW = $clog2(WIDTH);
   state_t           state, state_nx;
   logic             buf_full, buf_dir, sh_dir, load, last, tc;
   logic [WIDTH-1:0] buf_data, sh;
   logic [IW-1:0]    idx;

   assign bus.in_ready = !buf_full;
   assign busy         = state == SHIFT;
   assign ser_en       = busy && tc;
   assign last         = idx == IW'(WIDTH - 1);
   assign done         = ser_en && last;
   assign ser_dir      = sh_dir;
   assign ser_out      = sh_dir == DIR_LEFT ? sh[WIDTH-1] : sh[0];

   bit_period_counter #(.DIV_W(DIV_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .en    (busy),
      .div   (bit_div),
      .tc    (tc)
   );

   // holding buffer: filled by the handshake, drained by an engine load; never both at once
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         buf_full <= 1'b0;
         buf_data <= '0;
         buf_dir  <= DIR_RIGHT;
      end else if (load)
         buf_full <= 1'b0;
      else if (bus.in_valid && !buf_full) begin
         buf_full <= 1'b1;
         buf_data <= bus.in_data;
         buf_dir  <= bus.in_dir;
      end

   // state register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else       state <= state_nx;

   // load from the buffer when idle or on the last strobe of a word, so words chain without a gap
   always_comb begin
      load     = buf_full && (state == IDLE || done);
      state_nx = load ? SHIFT : done ? IDLE : state;
   end

   // shift register moves one bit toward the ser_out end on every strobe
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sh     <= '0;
         sh_dir <= DIR_RIGHT;
         idx    <= '0;
      end else if (load) begin
         sh     <= buf_data;
         sh_dir <= buf_dir;
         idx    <= '0;
      end else if (ser_en) begin
         sh  <= sh_dir == DIR_LEFT ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
         idx <= idx + 1'b1;
      end
endmodule

// File: tb/tb_nibble_serial_tx.sv
// tb_nibble_serial_tx: directed checks of the nibble serial transmitter against a model receiver
module tb_nibble_serial_tx;
   import nibble_link_pkg::*;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] bit_div = '0;
   logic       ser_out, ser_en, ser_dir, busy, done;
   int         cyc = 0, en_cnt = 0, done_cnt = 0, n_checks = 0, n_fail = 0;
   int         c0, idle;
   bit         bits[$];
   int         en_at[$], done_at[$];
   logic [3:0] rx = '0;

   nibble_serial_tx_if #(.WIDTH(4)) bus ();

   nibble_serial_tx #(.WIDTH(4), .DIV_W(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus.slave),
      .bit_div (bit_div),
      .ser_out (ser_out),
      .ser_en  (ser_en),
      .ser_dir (ser_dir),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // cycle stamp
   always @(posedge clk) cyc <= cyc + 1;

   // receiver model: samples mid-cycle and shifts on each strobe in the advertised direction
   always @(negedge clk) begin
      if (!reset && ser_en) begin
         bits.push_back(ser_out);
         en_at.push_back(cyc);
         en_cnt++;
         rx = ser_dir ? {rx[2:0], ser_out} : {ser_out, rx[3:1]};
      end
      if (!reset && done) begin
         done_cnt++;
         done_at.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear();
      bits.delete();
      en_at.delete();
      done_at.delete();
      en_cnt = 0;
      done_cnt = 0;
      rx = '0;
   endtask

   function automatic logic [5:0] outs();
      return {bus.in_ready, ser_out, ser_en, ser_dir, busy, done};
   endfunction

   function automatic logic [31:0] packed_bits();
      logic [31:0] v = '0;
      foreach (bits[i]) v = {v[30:0], bits[i]};
      return v;
   endfunction

   function automatic int en_stamp(input int i);
      return i < en_at.size() ? en_at[i] : -1000;
   endfunction

   function automatic int done_stamp(input int i);
      return i < done_at.size() ? done_at[i] : -1000;
   endfunction

   task automatic offer(input logic [3:0] d, input logic dir);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_dir   = dir;
      while (!bus.in_ready && t < 100) begin
         tick();
         t++;
      end
      tick();
      check("handshake_timeout", 32'(t < 100), 1);
      bus.in_valid = 1'b0;
      bus.in_data  = ~d;
      bus.in_dir   = ~dir;
   endtask

   task automatic wait_done(input int n, input int budget, output int idle_cycles);
      idle_cycles = 0;
      for (int i = 0; i < budget && done_cnt < n; i++) begin
         tick();
         if (!busy && done_cnt < n) idle_cycles++;
      end
      check("done_timeout", done_cnt, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_dir   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", outs(), 6'b100000);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_hold", outs(), 6'b100000);
      end
      // 1011 LSB first, one bit per cycle
      clear();
      bit_div = 8'd0;
      offer(4'b1011, DIR_RIGHT);
      check("t2_ready_full", bus.in_ready, 0);
      check("t2_busy_pre", busy, 0);
      tick();
      c0 = cyc;
      check("t2_busy", busy, 1);
      check("t2_dir", ser_dir, 0);
      check("t2_first_bit", ser_out, 1);
      check("t2_ready_back", bus.in_ready, 1);
      wait_done(1, 50, idle);
      check("t2_seq", packed_bits(), 32'b1101);
      check("t2_rx", rx, 4'b1011);
      check("t2_en_cnt", en_cnt, 4);
      check("t2_en_span", en_stamp(3) - en_stamp(0), 3);
      check("t2_done_at", done_stamp(0) - c0, 3);
      check("t2_idle_after", busy, 0);
      // 1011 MSB first, three cycles per bit
      clear();
      bit_div = 8'd2;
      offer(4'b1011, DIR_LEFT);
      tick();
      c0 = cyc;
      check("t3_dir", ser_dir, 1);
      check("t3_first_bit", ser_out, 1);
      wait_done(1, 80, idle);
      check("t3_seq", packed_bits(), 32'b1011);
      check("t3_rx", rx, 4'b1011);
      check("t3_first_en", en_stamp(0) - c0, 2);
      check("t3_en_period", en_stamp(1) - en_stamp(0), 3);
      check("t3_done_at", done_stamp(0) - c0, 11);
      // back-to-back A then 5
      clear();
      bit_div = 8'd1;
      offer(4'hA, DIR_RIGHT);
      offer(4'h5, DIR_RIGHT);
      check("t4_ready_full", bus.in_ready, 0);
      wait_done(2, 100, idle);
      check("t4_no_gap", idle, 0);
      check("t4_seq", packed_bits(), 32'h5A);
      check("t4_done_gap", done_stamp(1) - done_stamp(0), 8);
      check("t4_en_boundary", en_stamp(4) - en_stamp(3), 2);
      check("t4_rx", rx, 4'h5);
      // reset in the middle of bit 2 with the buffer full
      clear();
      bit_div = 8'd3;
      offer(4'hC, DIR_LEFT);
      offer(4'h3, DIR_RIGHT);
      for (int t = 0; t < 200 && en_cnt < 2; t++) tick();
      check("t5_reach_bit2", en_cnt, 2);
      tick();
      check("t5_ready_full", bus.in_ready, 0);
      #2 reset = 1'b1;
      #1;
      check("t5_reset_outs", outs(), 6'b100000);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) tick();
      check("t5_busy_after", busy, 0);
      check("t5_ready_after", bus.in_ready, 1);
      check("t5_no_done", done_cnt, 0);
      clear();
      bit_div = 8'd0;
      offer(4'h6, DIR_LEFT);
      wait_done(1, 50, idle);
      check("t5_seq", packed_bits(), 32'b0110);
      check("t5_rx", rx, 4'h6);
      // bit_div change mid-word takes effect only at the next load
      clear();
      bit_div = 8'd3;
      offer(4'h9, DIR_RIGHT);
      tick();
      tick();
      bit_div = 8'd0;
      offer(4'h3, DIR_RIGHT);
      wait_done(2, 100, idle);
      check("t6_seq", packed_bits(), 32'h9C);
      check("t6_old_period", en_stamp(1) - en_stamp(0), 4);
      check("t6_old_span", en_stamp(3) - en_stamp(0), 12);
      check("t6_boundary", en_stamp(4) - en_stamp(3), 1);
      check("t6_new_span", en_stamp(7) - en_stamp(4), 3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
